// File: rtl/encoder_arbiter_ctrl.sv
// encoder_arbiter_ctrl: shares one downstream port between N requesters.
// Highest requesting index wins and its ID is binary-encoded. The arbiter adds
// grant hold, a one-cycle release gap, starvation preemption after MAX_HOLD
// cycles and enable gating.
// Optional build macro ROUND_ROBIN_EN: the winner search starts one below the
// last grantee and wraps, so the most recent grantee has the lowest priority.
// When the macro is undefined the arbiter uses fixed priority.
module encoder_arbiter_ctrl #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDW      = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           preempt
);

  // Index space padded to 2**IDW so every select uses an exactly IDW-bit index.
  localparam int unsigned PW  = 1 << IDW;
  localparam int unsigned HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [HCW-1:0] HoldMax  = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HoldLast = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
  localparam logic [N-1:0]   OneN     = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e           state_q;
  logic [HCW-1:0]   hold_cnt_q;
  logic [N-1:0]     mask_q;
`ifdef ROUND_ROBIN_EN
  logic [IDW-1:0]   last_id_q;
`endif

  logic [N-1:0]     masked;
  logic [PW-1:0]    masked_pad;
  logic [PW-1:0]    req_pad;
  logic [N-1:0]     others;
  logic [IDW-1:0]   winner;
  logic             win_found;
  logic             preempt_due;

  assign masked     = req & ~mask_q;
  assign masked_pad = PW'(masked);
  assign req_pad    = PW'(req);
  // Requests from everyone except the current holder (gnt is one-hot of gnt_id).
  assign others     = req & ~gnt;

  assign preempt_due = (MAX_HOLD != 0) && (hold_cnt_q == HoldLast) && (others != '0);

`ifdef ROUND_ROBIN_EN
  int unsigned rr_start;
  int unsigned rr_idx;

  // Winner search: start one below the last grantee, walk downward with wrap.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    rr_start  = (last_id_q == '0) ? (N - 1) : (int'(last_id_q) - 1);
    rr_idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      rr_idx = (rr_start >= k) ? (rr_start - k) : (rr_start + N - k);
      if (!win_found && masked_pad[IDW'(rr_idx)]) begin
        winner    = IDW'(rr_idx);
        win_found = 1'b1;
      end
    end
  end
`else
  // Winner search: fixed priority, the highest set index overrides lower ones.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (masked[i]) begin
        winner    = IDW'(i);
        win_found = 1'b1;
      end
    end
  end
`endif

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt        <= '0;
      gnt_id     <= '0;
      gnt_valid  <= 1'b0;
      preempt    <= 1'b0;
      hold_cnt_q <= '0;
      mask_q     <= '0;
`ifdef ROUND_ROBIN_EN
      last_id_q  <= '0;
`endif
    end else begin
      preempt <= 1'b0;
      case (state_q)
        StIdle: begin
          if (en && win_found) begin
            state_q    <= StGrant;
            gnt        <= OneN << winner;
            gnt_id     <= winner;
            gnt_valid  <= 1'b1;
            hold_cnt_q <= '0;
            mask_q     <= '0;
`ifdef ROUND_ROBIN_EN
            last_id_q  <= winner;
`endif
          end else if ((masked == '0) && (req != '0)) begin
            // Only the preempted requester is asking: lift the mask and retry.
            mask_q <= '0;
          end
        end

        StGrant: begin
          if (hold_cnt_q != HoldMax) begin
            hold_cnt_q <= hold_cnt_q + HCW'(1);
          end
          if (!en || !req_pad[gnt_id]) begin
            state_q   <= StRelease;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
          end else if (preempt_due) begin
            state_q   <= StRelease;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b1;
            // Keep the revoked holder out of the very next arbitration.
            mask_q    <= gnt;
          end
        end

        StRelease: begin
          state_q <= StIdle;
        end

        default: begin
          state_q   <= StIdle;
          gnt       <= '0;
          gnt_id    <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
